// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states, datapath select
// encodings and instruction field positions.
package mc_pkg;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAddi = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsAddi,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsJmp,
    ClsHalt,
    ClsIllegal
  } iclass_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg = 2'b00;
  localparam logic [1:0] SrcBOne = 2'b01;
  localparam logic [1:0] SrcBImm = 2'b10;

  // Field LSB positions within the instruction word.
  localparam int unsigned OpLsb    = 12;
  localparam int unsigned F1Lsb    = 9;
  localparam int unsigned F2Lsb    = 6;
  localparam int unsigned F3Lsb    = 3;
  localparam int unsigned Imm6Msb  = 5;
  localparam int unsigned Imm12Msb = 11;

  function automatic logic [2:0] rtype_alu_op(input logic [3:0] op);
    logic [2:0] res;
    unique case (op)
      OpSub:   res = AluSub;
      OpAnd:   res = AluAnd;
      OpOr:    res = AluOr;
      default: res = AluAdd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decode: IR to register addresses, immediate, class and illegal flag.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic [DW-1:0] ir,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  output logic [AW-1:0] rc,
  output logic [DW-1:0] imm,
  output iclass_e       iclass,
  output logic          illegal
);

  logic [3:0]    opcode;
  logic [AW-1:0] f1, f2, f3;
  logic [DW-1:0] imm6_sext, imm12_zext;

  assign opcode     = ir[OpLsb +: 4];
  assign f1         = ir[F1Lsb +: AW];
  assign f2         = ir[F2Lsb +: AW];
  assign f3         = ir[F3Lsb +: AW];
  assign imm6_sext  = {{(DW-Imm6Msb-1){ir[Imm6Msb]}}, ir[Imm6Msb:0]};
  assign imm12_zext = {{(DW-Imm12Msb-1){1'b0}}, ir[Imm12Msb:0]};

  always_comb begin
    ra      = '0;
    rb      = '0;
    rc      = '0;
    imm     = '0;
    iclass  = ClsIllegal;
    illegal = 1'b0;
    unique case (opcode)
      OpAdd, OpSub, OpAnd, OpOr: begin
        iclass = ClsRtype;
        rc     = f1;
        ra     = f2;
        rb     = f3;
      end
      OpAddi, OpLw: begin
        iclass = (opcode == OpLw) ? ClsLw : ClsAddi;
        rc     = f1;
        ra     = f2;
        imm    = imm6_sext;
      end
      OpSw: begin
        iclass = ClsSw;
        rb     = f1;
        ra     = f2;
        imm    = imm6_sext;
      end
      OpBeq: begin
        iclass = ClsBeq;
        ra     = f1;
        rb     = f2;
        imm    = imm6_sext;
      end
      OpJmp: begin
        iclass = ClsJmp;
        imm    = imm12_zext;
      end
      OpHalt:  iclass = ClsHalt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM with instruction register. Define MC_ILLEGAL_TRAP_EN to make an illegal
// opcode halt the machine instead of acting as a NOP.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          mem_ready,
  input  logic          zero,
  output logic          mem_read,
  output logic          mem_write,
  output logic          iord,
  output logic          pc_write,
  output logic [1:0]    pc_src,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  output logic [AW-1:0] rc,
  output logic          reg_write,
  output logic          wd_sel,
  output logic          alu_src_a,
  output logic [1:0]    alu_src_b,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] imm,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [DW-1:0] ir_q;
  iclass_e       iclass;
  logic          illegal;

  mc_decoder #(
    .DW(DW),
    .AW(AW)
  ) u_decoder (
    .ir     (ir_q),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .imm    (imm),
    .iclass (iclass),
    .illegal(illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (state_q == StFetch && mem_ready) begin
      ir_q <= instr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StFetch;
`endif
        end else begin
          case (iclass)
            ClsJmp:  state_d = StFetch;
            ClsHalt: state_d = StHalt;
            default: state_d = StExec;
          endcase
        end
      end
      StExec: begin
        case (iclass)
          ClsBeq:       state_d = StFetch;
          ClsLw, ClsSw: state_d = StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem:   if (mem_ready) state_d = (iclass == ClsLw) ? StWb : StFetch;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are forced to zero while rst is high so an aborted access drops immediately.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PcSrcAlu;
    reg_write = 1'b0;
    wd_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SrcBReg;
    alu_op    = AluAdd;
    halted    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SrcBOne;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b = SrcBImm;
          if (!illegal && iclass == ClsJmp) begin
            pc_write = 1'b1;
            pc_src   = PcSrcJump;
          end
        end
        StExec: begin
          alu_src_a = 1'b1;
          case (iclass)
            ClsRtype: alu_op = rtype_alu_op(ir_q[OpLsb +: 4]);
            ClsBeq: begin
              alu_op   = AluSub;
              pc_src   = PcSrcAluOut;
              pc_write = zero;
            end
            default:  alu_src_b = SrcBImm;
          endcase
        end
        StMem: begin
          iord      = 1'b1;
          mem_read  = (iclass == ClsLw);
          mem_write = (iclass == ClsSw);
        end
        StWb: begin
          reg_write = (rc != '0);
          wd_sel    = (iclass == ClsLw);
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: hand-computed control outputs per cycle of each instruction.
module tb_mc_control_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        mem_read, mem_write, iord, pc_write, reg_write, wd_sel, alu_src_a, halted;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  ra, rb, rc, alu_op;
  logic [15:0] imm;
  logic [39:0] all_outs;

  int checks = 0;
  int errors = 0;

  mc_control_unit #(
    .DW(16),
    .AW(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .mem_ready(mem_ready),
    .zero     (zero),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .iord     (iord),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .reg_write(reg_write),
    .wd_sel   (wd_sel),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op   (alu_op),
    .imm      (imm),
    .halted   (halted)
  );

  assign all_outs = {mem_read, mem_write, iord, pc_write, pc_src, ra, rb, rc, reg_write, wd_sel,
                     alu_src_a, alu_src_b, alu_op, imm, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 16'h0000;
    mem_ready = 1'b0;
    zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_all_outputs", all_outs, 40'h0);

    // ADD r5 = r1 + r2, zero wait states
    instr     = 16'h0A50;
    mem_ready = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("add_fetch_mem_read", mem_read, 1);
    chk("add_fetch_iord", iord, 0);
    chk("add_fetch_pc_write", pc_write, 1);
    chk("add_fetch_pc_src", pc_src, 0);
    chk("add_fetch_src_b", alu_src_b, 1);
    tick();
    chk("add_dec_regs", {ra, rb, rc}, {3'd1, 3'd2, 3'd5});
    chk("add_dec_strobes", {mem_read, pc_write, reg_write}, 0);
    chk("add_dec_src_b", alu_src_b, 2);
    tick();
    chk("add_exec_alu", {alu_src_a, alu_src_b, alu_op}, {1'b1, 2'b00, 3'b000});
    chk("add_exec_reg_write", reg_write, 0);
    tick();
    chk("add_wb_reg_write", reg_write, 1);
    chk("add_wb_rc", rc, 5);
    chk("add_wb_wd_sel", wd_sel, 0);
    instr = 16'h5A7F;
    tick();
    chk("add_done_fetch", {mem_read, reg_write}, 2'b10);

    // LW r5 = mem[r1 - 1], two wait states in MEM
    tick();
    chk("lw_dec_imm", imm, 16'hFFFF);
    chk("lw_dec_regs", {ra, rc}, {3'd1, 3'd5});
    tick();
    chk("lw_exec_alu", {alu_src_a, alu_src_b, alu_op}, {1'b1, 2'b10, 3'b000});
    mem_ready = 1'b0;
    tick();
    chk("lw_mem1", {mem_read, mem_write, iord}, 3'b101);
    tick();
    chk("lw_mem2", {mem_read, mem_write, iord}, 3'b101);
    mem_ready = 1'b1;
    #1;
    chk("lw_mem3", {mem_read, mem_write, iord, reg_write}, 4'b1010);
    tick();
    chk("lw_wb", {mem_read, reg_write, wd_sel}, 3'b011);
    instr = 16'h7283;
    zero  = 1'b1;
    tick();
    chk("lw_done_fetch", {mem_read, iord, reg_write}, 3'b100);

    // BEQ taken
    tick();
    chk("beq_dec", {ra, rb, imm}, {3'd1, 3'd2, 16'h0003});
    tick();
    chk("beq_taken_pc", {pc_write, pc_src, alu_op}, {1'b1, 2'b01, 3'b001});
    tick();
    chk("beq_taken_fetch", {mem_read, pc_write}, 2'b11);

    // BEQ not taken
    zero = 1'b0;
    tick();
    tick();
    chk("beq_not_taken_pc", pc_write, 0);
    instr = 16'h4047;
    tick();
    chk("beq_not_taken_fetch", mem_read, 1);

    // ADDI with rc = 0 must not write the register file
    tick();
    chk("addi_dec", {ra, rc, imm}, {3'd1, 3'd0, 16'h0007});
    tick();
    tick();
    chk("addi_wb_no_write", reg_write, 0);
    instr = 16'h8123;
    tick();
    chk("addi_done_fetch", mem_read, 1);

    // JMP
    tick();
    chk("jmp_dec", {pc_write, pc_src, imm}, {1'b1, 2'b10, 16'h0123});
    instr = 16'h9000;
    tick();
    chk("jmp_done_fetch", mem_read, 1);

    // Illegal opcode
    tick();
    chk("illegal_dec_strobes", {mem_read, mem_write, pc_write, reg_write, halted}, 0);
    instr = 16'hF000;
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_trap_halted", {halted, mem_read}, 2'b10);
    rst = 1'b1;
    tick();
    #3 rst = 1'b0;
    #1;
    chk("illegal_trap_restart", {mem_read, halted}, 2'b10);
`else
    chk("illegal_nop_fetch", {mem_read, halted, pc_write}, 3'b101);
`endif

    // HALT is sticky until reset
    tick();
    tick();
    chk("halt_entered", {halted, mem_read, pc_write}, 3'b100);
    tick();
    tick();
    chk("halt_sticky", {halted, mem_read, mem_write, pc_write, reg_write}, 5'b10000);
    rst = 1'b1;
    #1;
    chk("halt_cleared_by_rst", all_outs, 40'h0);
    instr = 16'h6A42;
    tick();
    #3 rst = 1'b0;
    #1;
    chk("halt_restart_fetch", {mem_read, iord}, 2'b10);

    // SW r5 -> mem[r1 + 2], zero wait states
    tick();
    chk("sw_dec", {ra, rb, rc, imm}, {3'd1, 3'd5, 3'd0, 16'h0002});
    tick();
    chk("sw_exec_alu", {alu_src_a, alu_src_b}, 3'b110);
    tick();
    chk("sw_mem", {mem_read, mem_write, iord}, 3'b011);
    tick();
    chk("sw_done_fetch", {mem_read, mem_write, iord}, 3'b100);

    // SW with a stalled MEM interrupted by reset
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_wait1", {mem_write, iord}, 2'b11);
    tick();
    chk("sw_wait2", {mem_write, iord}, 2'b11);
    rst = 1'b1;
    #1;
    chk("sw_abort_outputs", all_outs, 40'h0);
    tick();
    #3 rst = 1'b0;
    #1;
    chk("sw_abort_restart", {mem_read, mem_write, iord}, 3'b100);
    tick();
    chk("sw_abort_fetch_hold", {mem_read, pc_write}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
